conv_window_feeder: RTL and testbench

- Upstream feeder for the SD4 MAC: accepts a raster-order 8-bit pixel stream and forms 3x3 sliding windows (valid convolution, no padding).
- Presents each window as the MAC's 72-bit image bus, together with the latched 36-bit weight and 5-bit exp_bias.
- Tracks MAC pipeline latency so every 16-bit MAC result can be tagged valid, and signals the end of each frame.

---
 rtl/conv_window_feeder.sv | 158 +++++++++++++++
 tb/tb_conv_window_feeder.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_feeder.sv
// 3x3 sliding-window former for the SD4 MAC: raster pixels in, 72-bit windows out,
// with latched kernel/bias and MAC-latency-aligned result valid and frame-done tracking.
`timescale 1ns/1ps
module conv_window_feeder #(
    parameter int unsigned IMG_W   = 8,
    parameter int unsigned IMG_H   = 8,
    parameter int unsigned MAC_LAT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        w_load,
    input  logic [35:0] w_in,
    input  logic [4:0]  bias_in,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [71:0] image,
    output logic [35:0] weight,
    output logic [4:0]  exp_bias,
    output logic        win_valid,
    output logic        out_valid,
    output logic        frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned CNT_W = $clog2(MAC_LAT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [CNT_W-1:0]   drain_cnt;
    logic [MAC_LAT-1:0] vld_dly;

    logic [7:0] line0 [IMG_W];
    logic [7:0] line1 [IMG_W];
    logic [7:0] win [9];
    logic [7:0] win_next [9];

    logic accept;
    logic last_col;
    logic last_row;
    logic emit;
    logic load_w;
    logic drain_done;

    // Next-state and strobe decode
    always_comb begin
        state_next = state;
        load_w     = 1'b0;
        drain_done = 1'b0;
        accept     = pix_valid && pix_ready;
        last_col   = (col == COL_W'(IMG_W - 1));
        last_row   = (row == ROW_W'(IMG_H - 1));
        emit       = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
        case (state)
            S_IDLE: begin
                if (w_load) begin
                    load_w     = 1'b1;
                    state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (accept && last_col && last_row) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Drain counter starts at zero in the cycle of the final win_valid
                if (drain_cnt == CNT_W'(MAC_LAT - 1)) begin
                    drain_done = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Window after shifting in the new right column (top to bottom: line1, line0, pixel)
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_next[3*r]     = win[3*r + 1];
            win_next[3*r + 1] = win[3*r + 2];
        end
        win_next[2] = line1[col];
        win_next[5] = line0[col];
        win_next[8] = pix_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_ready  <= 1'b0;
            image      <= '0;
            weight     <= '0;
            exp_bias   <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            vld_dly    <= '0;
            col        <= '0;
            row        <= '0;
            drain_cnt  <= '0;
        end else begin
            pix_ready  <= (state_next == S_STREAM);
            win_valid  <= emit;
            frame_done <= drain_done;
            vld_dly    <= MAC_LAT'({vld_dly, win_valid});
            if (emit) begin
                image <= {win_next[0], win_next[1], win_next[2],
                          win_next[3], win_next[4], win_next[5],
                          win_next[6], win_next[7], win_next[8]};
            end
            if (load_w) begin
                weight   <= w_in;
                exp_bias <= bias_in;
            end
            if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + CNT_W'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    // Line buffers and window carry no reset; validity comes from the counters
    always_ff @(posedge clk) begin
        if (accept) begin
            line1[col] <= line0[col];
            line0[col] <= pix_in;
            for (int i = 0; i < 9; i++) begin
                win[i] <= win_next[i];
            end
        end
    end

    assign out_valid = vld_dly[MAC_LAT-1];

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder: three instances (4x4, 5x5, 5x3) driven one at a time.
`timescale 1ns/1ps
module tb_conv_window_feeder;

    logic        clk = 1'b0;
    logic        rst [3];
    logic        w_load [3];
    logic [35:0] w_in [3];
    logic [4:0]  bias_in [3];
    logic [7:0]  pix_in [3];
    logic        pix_valid [3];
    logic        pix_ready [3];
    logic [71:0] image [3];
    logic [35:0] weight [3];
    logic [4:0]  exp_bias [3];
    logic        win_valid [3];
    logic        out_valid [3];
    logic        frame_done [3];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int stall_viol = 0;
    logic prev_acc [3];

    logic [71:0] wins [$];
    int wv_cyc [$];
    int ov_cyc [$];
    int fd_cyc [$];

    conv_window_feeder #(.IMG_W(4), .IMG_H(4), .MAC_LAT(5)) u_a (
        .clk(clk), .rst(rst[0]), .w_load(w_load[0]), .w_in(w_in[0]), .bias_in(bias_in[0]),
        .pix_in(pix_in[0]), .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]),
        .image(image[0]), .weight(weight[0]), .exp_bias(exp_bias[0]),
        .win_valid(win_valid[0]), .out_valid(out_valid[0]), .frame_done(frame_done[0]));

    conv_window_feeder #(.IMG_W(5), .IMG_H(5), .MAC_LAT(5)) u_b (
        .clk(clk), .rst(rst[1]), .w_load(w_load[1]), .w_in(w_in[1]), .bias_in(bias_in[1]),
        .pix_in(pix_in[1]), .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]),
        .image(image[1]), .weight(weight[1]), .exp_bias(exp_bias[1]),
        .win_valid(win_valid[1]), .out_valid(out_valid[1]), .frame_done(frame_done[1]));

    conv_window_feeder #(.IMG_W(5), .IMG_H(3), .MAC_LAT(5)) u_c (
        .clk(clk), .rst(rst[2]), .w_load(w_load[2]), .w_in(w_in[2]), .bias_in(bias_in[2]),
        .pix_in(pix_in[2]), .pix_valid(pix_valid[2]), .pix_ready(pix_ready[2]),
        .image(image[2]), .weight(weight[2]), .exp_bias(exp_bias[2]),
        .win_valid(win_valid[2]), .out_valid(out_valid[2]), .frame_done(frame_done[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled mid-cycle
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (win_valid[k] === 1'b1) begin
                wins.push_back(image[k]);
                wv_cyc.push_back(cyc);
                if (prev_acc[k] !== 1'b1) stall_viol++;
            end
            if (out_valid[k] === 1'b1) ov_cyc.push_back(cyc);
            if (frame_done[k] === 1'b1) fd_cyc.push_back(cyc);
            prev_acc[k] = pix_valid[k] && pix_ready[k];
        end
    end

    // Expected window whose top-left pixel value is v in a raster frame of width w
    function automatic logic [71:0] win_of(input int v, input int w);
        logic [71:0] r;
        r = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                r = {r[63:0], 8'(v + i*w + j)};
        return r;
    endfunction

    task automatic clear_log();
        wins.delete();
        wv_cyc.delete();
        ov_cyc.delete();
        fd_cyc.delete();
        stall_viol = 0;
    endtask

    task automatic load(input int k, input logic [35:0] w, input logic [4:0] b);
        w_load[k] = 1'b1;
        w_in[k] = w;
        bias_in[k] = b;
        @(posedge clk); #1;
        w_load[k] = 1'b0;
    endtask

    task automatic send(input int k, input int first, input int n,
                        input int stall_every, input int stall_len, input int junk_at);
        for (int p = 0; p < n; p++) begin
            pix_in[k] = 8'(first + p);
            pix_valid[k] = 1'b1;
            if (p == junk_at) begin
                w_load[k] = 1'b1;
                w_in[k] = '0;
                bias_in[k] = '0;
            end
            @(posedge clk); #1;
            w_load[k] = 1'b0;
            if (stall_every > 0 && ((p + 1) % stall_every) == 0) begin
                pix_valid[k] = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk); #1;
                end
            end
        end
        pix_valid[k] = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int t;
        t = 0;
        while (fd_cyc.size() < n && t < 80) begin
            @(posedge clk); #1;
            t++;
        end
        vectors++;
        if (fd_cyc.size() < n) begin
            miscompares++;
            $display("FAIL frame_done_timeout: got %0d pulses, required %0d", fd_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({pix_ready[k], win_valid[k], out_valid[k], frame_done[k],
                 image[k], weight[k], exp_bias[k]} !== 117'd0) begin
                miscompares++;
                $display("FAIL reset_outputs[%0d]: got ready=%b img=%h w=%h", k,
                         pix_ready[k], image[k], weight[k]);
            end
        end
    endtask

    task automatic test_basic();
        int idx;
        clear_log();
        load(0, 36'h123456789, 5'd15);
        send(0, 1, 16, 0, 0, -1);
        wait_done(1);
        vectors++;
        if (wins.size() != 4) begin
            miscompares++;
            $display("FAIL basic_win_count: got %0d, required 4", wins.size());
        end
        idx = 0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                vectors++;
                if (idx >= wins.size() || wins[idx] !== win_of(1 + r*4 + c, 4)) begin
                    miscompares++;
                    $display("FAIL basic_window[%0d]: got %h, required %h", idx,
                             (idx < wins.size()) ? wins[idx] : 72'd0, win_of(1 + r*4 + c, 4));
                end
                idx++;
            end
        end
        vectors++;
        if (weight[0] !== 36'h123456789 || exp_bias[0] !== 5'd15) begin
            miscompares++;
            $display("FAIL basic_weight: got %h/%0d, required 123456789/15", weight[0], exp_bias[0]);
        end
        vectors++;
        if (ov_cyc.size() != 4) begin
            miscompares++;
            $display("FAIL latency_count: got %0d out_valid, required 4", ov_cyc.size());
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= ov_cyc.size() || i >= wv_cyc.size() || ov_cyc[i] - wv_cyc[i] != 5) begin
                miscompares++;
                $display("FAIL latency[%0d]: got %0d cycles, required 5", i,
                         (i < ov_cyc.size() && i < wv_cyc.size()) ? ov_cyc[i] - wv_cyc[i] : -1);
            end
        end
        vectors++;
        if (fd_cyc.size() < 1 || ov_cyc.size() < 4 || fd_cyc[0] != ov_cyc[3]) begin
            miscompares++;
            $display("FAIL frame_done_align: got cycle %0d, required %0d",
                     (fd_cyc.size() > 0) ? fd_cyc[0] : -1, (ov_cyc.size() > 3) ? ov_cyc[3] : -1);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (pix_ready[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL ready_after_done: got %b, required 0", pix_ready[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        int idx;
        clear_log();
        load(0, 36'h123456789, 5'd15);
        send(0, 1, 16, 2, 3, -1);
        wait_done(1);
        vectors++;
        if (wins.size() != 4) begin
            miscompares++;
            $display("FAIL stall_win_count: got %0d, required 4", wins.size());
        end
        idx = 0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                vectors++;
                if (idx >= wins.size() || wins[idx] !== win_of(1 + r*4 + c, 4)) begin
                    miscompares++;
                    $display("FAIL stall_window[%0d]: got %h, required %h", idx,
                             (idx < wins.size()) ? wins[idx] : 72'd0, win_of(1 + r*4 + c, 4));
                end
                idx++;
            end
        end
        vectors++;
        if (stall_viol != 0) begin
            miscompares++;
            $display("FAIL stall_win_after_idle: got %0d, required 0", stall_viol);
        end
    endtask

    task automatic test_ignored_inputs();
        int idx;
        clear_log();
        pix_in[0] = 8'd99;
        pix_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (pix_ready[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_ready: got %b, required 0", pix_ready[0]);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (wins.size() != 0) begin
            miscompares++;
            $display("FAIL idle_windows: got %0d, required 0", wins.size());
        end
        // w_load together with pix_valid=99 in IDLE: pixel 99 must not enter the window
        load(0, 36'h123456789, 5'd15);
        send(0, 1, 16, 0, 0, 4);
        wait_done(1);
        vectors++;
        if (wins.size() != 4) begin
            miscompares++;
            $display("FAIL ignored_win_count: got %0d, required 4", wins.size());
        end
        idx = 0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                vectors++;
                if (idx >= wins.size() || wins[idx] !== win_of(1 + r*4 + c, 4)) begin
                    miscompares++;
                    $display("FAIL ignored_window[%0d]: got %h, required %h", idx,
                             (idx < wins.size()) ? wins[idx] : 72'd0, win_of(1 + r*4 + c, 4));
                end
                idx++;
            end
        end
        vectors++;
        if (weight[0] !== 36'h123456789 || exp_bias[0] !== 5'd15) begin
            miscompares++;
            $display("FAIL stream_wload_ignored: got %h/%0d, required 123456789/15",
                     weight[0], exp_bias[0]);
        end
    endtask

    task automatic test_reset_midframe();
        int idx;
        clear_log();
        load(1, 36'h0abcdef12, 5'd7);
        send(1, 1, 9, 0, 0, -1);
        #2;
        rst[1] = 1'b1;
        #1;
        vectors++;
        if ({pix_ready[1], win_valid[1], out_valid[1], frame_done[1],
             image[1], weight[1], exp_bias[1]} !== 117'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got ready=%b w=%h bias=%0d", pix_ready[1],
                     weight[1], exp_bias[1]);
        end
        #1;
        rst[1] = 1'b0;
        @(posedge clk); #1;
        clear_log();
        repeat (10) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (ov_cyc.size() != 0 || fd_cyc.size() != 0 || pix_ready[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_stale: got ov=%0d fd=%0d ready=%b, required 0/0/0",
                     ov_cyc.size(), fd_cyc.size(), pix_ready[1]);
        end
        load(1, 36'h0abcdef12, 5'd7);
        send(1, 1, 25, 0, 0, -1);
        wait_done(1);
        vectors++;
        if (wins.size() != 9) begin
            miscompares++;
            $display("FAIL midreset_win_count: got %0d, required 9", wins.size());
        end
        idx = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                vectors++;
                if (idx >= wins.size() || wins[idx] !== win_of(1 + r*5 + c, 5)) begin
                    miscompares++;
                    $display("FAIL midreset_window[%0d]: got %h, required %h", idx,
                             (idx < wins.size()) ? wins[idx] : 72'd0, win_of(1 + r*5 + c, 5));
                end
                idx++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        clear_log();
        load(2, 36'h111111111, 5'd3);
        send(2, 1, 15, 0, 0, -1);
        wait_done(1);
        load(2, 36'h222222222, 5'd4);
        send(2, 101, 15, 0, 0, -1);
        wait_done(2);
        vectors++;
        if (wins.size() != 6) begin
            miscompares++;
            $display("FAIL b2b_win_count: got %0d, required 6", wins.size());
        end
        idx = 0;
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < 3; c++) begin
                vectors++;
                if (idx >= wins.size() || wins[idx] !== win_of(1 + 100*f + c, 5)) begin
                    miscompares++;
                    $display("FAIL b2b_window[%0d]: got %h, required %h", idx,
                             (idx < wins.size()) ? wins[idx] : 72'd0, win_of(1 + 100*f + c, 5));
                end
                idx++;
            end
        end
        vectors++;
        if (weight[2] !== 36'h222222222 || exp_bias[2] !== 5'd4) begin
            miscompares++;
            $display("FAIL b2b_weight: got %h/%0d, required 222222222/4", weight[2], exp_bias[2]);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            w_load[k] = 1'b0;
            w_in[k] = '0;
            bias_in[k] = '0;
            pix_in[k] = '0;
            pix_valid[k] = 1'b0;
            prev_acc[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_basic();
        test_stall();
        test_ignored_inputs();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
